// File: rtl/atm_pkg.sv
// Shared ATM definitions: note codes, denomination values and
// the note dispenser state encoding.
package atm_pkg;

   localparam int NUM_NOTES = 6;

   typedef enum logic [2:0] {
      NOTE_1   = 3'd0,
      NOTE_5   = 3'd1,
      NOTE_10  = 3'd2,
      NOTE_20  = 3'd3,
      NOTE_50  = 3'd4,
      NOTE_100 = 3'd5
   } note_t;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      ISSUE,
      GAP,
      DONE,
      FAULT
   } state_t;

   function automatic logic [7:0] note_value(note_t c);
      logic [7:0] v;
      unique case (c)
         NOTE_5:   v = 8'd5;
         NOTE_10:  v = 8'd10;
         NOTE_20:  v = 8'd20;
         NOTE_50:  v = 8'd50;
         NOTE_100: v = 8'd100;
         default:  v = 8'd1;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/denom_select.sv
// Greedy denomination picker: largest note value that still fits
// in the remaining amount.
module denom_select
   import atm_pkg::*;
#(
   parameter int AMT_W = 8
) (
   input  logic [AMT_W-1:0] remaining,
   output note_t            code,
   output logic [AMT_W-1:0] value,
   output logic             zero
);

   always_comb begin
      code = NOTE_1;
      // ascending scan, so the last fitting note is the largest
      for (int i = 0; i < NUM_NOTES; i++) begin
         if (remaining >= AMT_W'(note_value(note_t'(i[2:0]))))
            code = note_t'(i[2:0]);
      end
      value = AMT_W'(note_value(code));
      zero  = (remaining == '0);
   end

endmodule

// File: rtl/note_dispenser.sv
// Breaks a withdrawal into notes, largest first, and hands them one
// at a time to the dispensing mechanism with a spacing gap.
module note_dispenser
   import atm_pkg::*;
#(
   parameter int AMT_W      = 8,
   parameter int GAP_CYCLES = 4,
   parameter int TIMEOUT    = 1000
) (
   input  logic             clk,
   input  logic             res,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   input  logic             abort,
   output logic             note_valid,
   output logic [2:0]       note_code,
   input  logic             note_ready,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [AMT_W-1:0] dispensed
);

   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   state_t           state_q, state_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic [AMT_W-1:0] disp_q, disp_d;
   logic             nv_q, nv_d;
   note_t            code_q, code_d;
   logic             done_q, done_d;
   logic             fault_q, fault_d;
   logic             busy_q, busy_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [TO_W-1:0]  to_q, to_d;

   note_t            sel_code;
   logic [AMT_W-1:0] sel_value;
   logic             sel_zero;
   logic             hs;

   denom_select #(
      .AMT_W(AMT_W)
   ) u_sel (
      .remaining(rem_q),
      .code     (sel_code),
      .value    (sel_value),
      .zero     (sel_zero)
   );

   assign hs = nv_q & note_ready;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      disp_d  = disp_q;
      nv_d    = nv_q;
      code_d  = code_q;
      gap_d   = gap_q;
      to_d    = to_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               rem_d   = amount;
               disp_d  = '0;
               state_d = SELECT;
            end
         end
         SELECT: begin
            if (abort) begin
               nv_d    = 1'b0;
               state_d = IDLE;
            end else if (sel_zero) begin
               state_d = DONE;
            end else begin
               code_d  = sel_code;
               nv_d    = 1'b1;
               to_d    = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // remaining is untouched since SELECT, so the picker
            // still reports the value of the pending note
            if (hs) begin
               rem_d   = rem_q - sel_value;
               disp_d  = disp_q + sel_value;
               nv_d    = 1'b0;
               gap_d   = GAP_W'(GAP_CYCLES - 1);
               state_d = abort ? IDLE : GAP;
            end else if (abort) begin
               nv_d    = 1'b0;
               state_d = IDLE;
            end else if (to_q == TO_W'(TIMEOUT - 1)) begin
               nv_d    = 1'b0;
               state_d = FAULT;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         GAP: begin
            if (abort) begin
               state_d = IDLE;
            end else if (gap_q == '0) begin
               state_d = SELECT;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         FAULT: begin
            if (abort)
               state_d = IDLE;
         end
         default: begin
            nv_d    = 1'b0;
            state_d = IDLE;
         end
      endcase
      done_d  = (state_d == DONE);
      fault_d = (state_d == FAULT);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= IDLE;
         rem_q   <= '0;
         disp_q  <= '0;
         nv_q    <= 1'b0;
         code_q  <= NOTE_1;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         busy_q  <= 1'b0;
         gap_q   <= '0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         disp_q  <= disp_d;
         nv_q    <= nv_d;
         code_q  <= code_d;
         done_q  <= done_d;
         fault_q <= fault_d;
         busy_q  <= busy_d;
         gap_q   <= gap_d;
         to_q    <= to_d;
      end
   end

   assign note_valid = nv_q;
   assign note_code  = code_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign fault      = fault_q;
   assign dispensed  = disp_q;

endmodule

// File: tb/tb_note_dispenser.sv
// Scoreboard bench for note_dispenser: greedy model feeds expected
// notes and totals, a negedge monitor checks what the DUT presents.
module tb_note_dispenser;

   localparam int GAP = 4;
   localparam int TMO = 16;

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       note_ready = 1'b0;
   logic [7:0] amount = '0;
   logic       note_valid, busy, done, fault;
   logic [2:0] note_code;
   logic [7:0] dispensed;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rmode = 0;
   int wcnt = 0;
   int hs_count = 0;
   int done_count = 0;
   int done_cyc = 0;
   int exp_code[$];
   int exp_done[$];
   int hs_cyc[$];
   logic       prev_pend = 1'b0;
   logic [2:0] prev_code = '0;

   note_dispenser #(
      .AMT_W     (8),
      .GAP_CYCLES(GAP),
      .TIMEOUT   (TMO)
   ) dut (
      .clk       (clk),
      .res       (res),
      .start     (start),
      .amount    (amount),
      .abort     (abort),
      .note_valid(note_valid),
      .note_code (note_code),
      .note_ready(note_ready),
      .busy      (busy),
      .done      (done),
      .fault     (fault),
      .dispensed (dispensed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // greedy break-down with plain division, largest note first
   function automatic void model(int amt);
      int vals[6] = '{1, 5, 10, 20, 50, 100};
      int r = amt;
      for (int c = 5; c >= 0; c--) begin
         int n = r / vals[c];
         r = r % vals[c];
         repeat (n) exp_code.push_back(c);
      end
   endfunction

   // mechanism model: 0 tied high, 1 random wait, 2 three-cycle wait, 3 stuck
   always @(posedge clk) begin
      #1;
      case (rmode)
         0: note_ready = 1'b1;
         1: begin
            if (note_valid && !note_ready) wcnt++;
            else wcnt = 0;
            note_ready = note_valid && (wcnt > 5 || $urandom_range(0, 1) == 1);
         end
         2: begin
            if (note_valid && !note_ready) wcnt++;
            else wcnt = 0;
            note_ready = note_valid && (wcnt > 3);
         end
         default: note_ready = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      if (!res) begin
         prev_pend = 1'b0;
      end else begin
         if (prev_pend && note_valid)
            chk("code_stable", note_code, prev_code);
         if (note_valid && note_ready) begin
            hs_count++;
            hs_cyc.push_back(cyc);
            if (exp_code.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL note_extra: got code %0d, none expected", note_code);
            end else begin
               chk("note_code", note_code, exp_code.pop_front());
            end
         end
         if (done) begin
            done_count++;
            done_cyc = cyc;
            if (exp_done.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done_extra: got done at cycle %0d, none expected", cyc);
            end else begin
               chk("done_dispensed", dispensed, exp_done.pop_front());
               chk("done_notes_left", exp_code.size(), 0);
            end
         end
         prev_pend = note_valid && !note_ready;
         prev_code = note_code;
      end
   end

   task automatic do_start(input int amt, output int k);
      tick();
      start  = 1'b1;
      amount = 8'(amt);
      k = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int d0;
      int i;
      d0 = done_count;
      i = 0;
      while (done_count == d0 && i < bound) begin
         tick();
         i++;
      end
      if (done_count == d0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done, required within %0d cycles", bound);
      end
   endtask

   task automatic wait_hs(input int n, input int bound);
      int i;
      i = 0;
      while (hs_count < n && i < bound) begin
         tick();
         i++;
      end
      if (hs_count < n) begin
         checks++;
         errors++;
         $display("FAIL hs_timeout: got %0d handshakes, required %0d", hs_count, n);
      end
   endtask

   initial begin
      int k;
      int vcnt;
      int base;
      int i;

      repeat (3) tick();
      chk("rst_valid", note_valid, 0);
      chk("rst_code", note_code, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fault", fault, 0);
      chk("rst_dispensed", dispensed, 0);
      res = 1'b1;
      repeat (2) tick();

      // 186 with ready tied high: codes 5..0 on a fixed cadence
      rmode = 0;
      hs_cyc.delete();
      model(186);
      exp_done.push_back(186);
      do_start(186, k);
      wait_done(200);
      chk("t186_hs_count", hs_cyc.size(), 6);
      if (hs_cyc.size() == 6) begin
         chk("t186_first_lat", hs_cyc[0] - k, 2);
         for (int j = 1; j < 6; j++)
            chk("t186_spacing", hs_cyc[j] - hs_cyc[j-1], GAP + 2);
         chk("t186_done_lat", done_cyc - hs_cyc[5], GAP + 2);
      end
      repeat (3) tick();

      // zero amount: no note, done two cycles after start
      exp_done.push_back(0);
      do_start(0, k);
      chk("t0_busy_k1", busy, 1);
      chk("t0_done_k1", done, 0);
      chk("t0_valid_k1", note_valid, 0);
      tick();
      chk("t0_busy_k2", busy, 1);
      chk("t0_done_k2", done, 1);
      chk("t0_valid_k2", note_valid, 0);
      tick();
      chk("t0_busy_k3", busy, 0);
      chk("t0_done_k3", done, 0);
      repeat (3) tick();

      // 40 with a slow mechanism
      rmode = 2;
      model(40);
      exp_done.push_back(40);
      do_start(40, k);
      wait_done(200);
      repeat (3) tick();

      // 7 with a stuck mechanism: fault after TMO issue cycles
      rmode = 3;
      do_start(7, k);
      vcnt = 0;
      for (i = 0; i < 60; i++) begin
         if (fault) break;
         if (note_valid) vcnt++;
         tick();
      end
      chk("t7_issue_cycles", vcnt, TMO);
      chk("t7_fault", fault, 1);
      chk("t7_valid", note_valid, 0);
      chk("t7_dispensed", dispensed, 0);
      chk("t7_busy", busy, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t7_abort_fault", fault, 0);
      chk("t7_abort_busy", busy, 0);
      repeat (3) tick();

      // 255 with a start pulse in GAP that must be ignored
      rmode = 0;
      model(255);
      exp_done.push_back(255);
      base = hs_count;
      do_start(255, k);
      wait_hs(base + 1, 20);
      start  = 1'b1;
      amount = 8'd9;
      tick();
      start = 1'b0;
      wait_done(200);
      repeat (20) tick();

      // reset while a note waits in ISSUE
      model(120);
      base = hs_count;
      do_start(120, k);
      wait_hs(base + 1, 20);
      rmode = 3;
      i = 0;
      while (!note_valid && i < 20) begin
         tick();
         i++;
      end
      chk("trst_reached_issue", note_valid, 1);
      chk("trst_partial", dispensed, 100);
      tick();
      res = 1'b0;
      #1;
      chk("trst_valid", note_valid, 0);
      chk("trst_busy", busy, 0);
      chk("trst_dispensed", dispensed, 0);
      exp_code.delete();
      repeat (2) tick();
      res = 1'b1;
      rmode = 0;
      repeat (10) tick();

      // 150 aborted in the second note's handshake cycle
      model(150);
      base = hs_count;
      do_start(150, k);
      i = 0;
      while (!(note_valid && hs_count == base + 1) && i < 40) begin
         tick();
         i++;
      end
      chk("t150_second_issue", note_valid, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t150_busy", busy, 0);
      chk("t150_valid", note_valid, 0);
      chk("t150_dispensed", dispensed, 150);
      chk("t150_notes_left", exp_code.size(), 0);
      repeat (10) tick();

      // randomized amounts against the greedy model
      rmode = 1;
      for (int n = 0; n < 25; n++) begin
         int amt;
         amt = $urandom_range(0, 255);
         model(amt);
         exp_done.push_back(amt);
         do_start(amt, k);
         wait_done(600);
         repeat ($urandom_range(1, 4)) tick();
      end
      repeat (5) tick();
      chk("end_notes_left", exp_code.size(), 0);
      chk("end_done_left", exp_done.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
